// File: rtl/sipo_10bit_aligner.sv
// Serial-to-parallel 10-bit word aligner: locks word phase on the K28.5 comma and
// re-aligns after a run of commas seen at the wrong bit offset.
module sipo_10bit_aligner #(
    parameter logic [9:0]  COMMA_P      = 10'h17C,
    parameter logic [9:0]  COMMA_N      = 10'h283,
    parameter int unsigned MISALIGN_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic [9:0] par_out,
    output logic       par_valid,
    output logic       comma_det,
    output logic       locked,
    output logic       realign
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] MIS_MAX = 4'(MISALIGN_MAX);

    state_t     state_q, state_d;
    logic [9:0] win_q, win_d;
    logic [3:0] fill_cnt_q, fill_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] misalign_cnt_q, misalign_cnt_d;
    logic [9:0] par_out_q, par_out_d;
    logic       par_valid_q, par_valid_d;
    logic       comma_det_q, comma_det_d;
    logic       locked_q, locked_d;
    logic       realign_q, realign_d;

    logic [9:0] nw;
    logic [3:0] mis_inc;
    logic       match;
    logic       emit;

    always_comb begin
        nw      = {ser_in, win_q[9:1]};
        // fill_cnt >= 9 guarantees nw holds ten genuinely received bits
        match   = ((nw == COMMA_P) || (nw == COMMA_N)) && (fill_cnt_q >= 4'd9);
        mis_inc = misalign_cnt_q + 4'd1;
        emit    = 1'b0;

        state_d        = state_q;
        win_d          = win_q;
        fill_cnt_d     = fill_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        misalign_cnt_d = misalign_cnt_q;
        par_out_d      = par_out_q;
        par_valid_d    = 1'b0;
        comma_det_d    = 1'b0;
        locked_d       = locked_q;
        realign_d      = 1'b0;

        if (ser_valid) begin
            win_d = nw;
            if (fill_cnt_q != 4'd10) begin
                fill_cnt_d = fill_cnt_q + 4'd1;
            end

            case (state_q)
                HUNT: begin
                    if (match) begin
                        emit           = 1'b1;
                        bit_cnt_d      = 4'd0;
                        misalign_cnt_d = 4'd0;
                        state_d        = LOCKED;
                        locked_d       = 1'b1;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q == 4'd9) begin
                        emit      = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (match) begin
                            misalign_cnt_d = 4'd0;
                        end
                    end else if (match) begin
                        if (mis_inc == MIS_MAX) begin
                            emit           = 1'b1;
                            realign_d      = 1'b1;
                            bit_cnt_d      = 4'd0;
                            misalign_cnt_d = 4'd0;
                        end else begin
                            misalign_cnt_d = mis_inc;
                            bit_cnt_d      = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (emit) begin
            par_out_d   = nw;
            par_valid_d = 1'b1;
            comma_det_d = match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            win_q          <= '0;
            fill_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            misalign_cnt_q <= '0;
            par_out_q      <= '0;
            par_valid_q    <= 1'b0;
            comma_det_q    <= 1'b0;
            locked_q       <= 1'b0;
            realign_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            fill_cnt_q     <= fill_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            misalign_cnt_q <= misalign_cnt_d;
            par_out_q      <= par_out_d;
            par_valid_q    <= par_valid_d;
            comma_det_q    <= comma_det_d;
            locked_q       <= locked_d;
            realign_q      <= realign_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign comma_det = comma_det_q;
    assign locked    = locked_q;
    assign realign   = realign_q;

endmodule

// File: tb/tb_sipo_10bit_aligner.sv
// Directed bench for sipo_10bit_aligner: locking, gapped input, re-alignment,
// misalign-count clearing and mid-word reset, with hand-computed expectations.
module tb_sipo_10bit_aligner;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       ser_in    = 1'b0;
    logic       ser_valid = 1'b0;
    logic [9:0] par_out;
    logic       par_valid;
    logic       comma_det;
    logic       locked;
    logic       realign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_10bit_aligner #(
        .COMMA_P      (10'h17C),
        .COMMA_N      (10'h283),
        .MISALIGN_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .par_out   (par_out),
        .par_valid (par_valid),
        .comma_det (comma_det),
        .locked    (locked),
        .realign   (realign)
    );

    // One clock per call; outputs are sampled 1ns after the edge that took the bit.
    task automatic send_bit(input logic b, input logic v);
        @(negedge clk);
        ser_in    = b;
        ser_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Reset with a valid bit present so reset priority is exercised too.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ser_valid = 1'b0;
    endtask

    task automatic lock_on_17c();
        logic [9:0] w;
        w = 10'h17C;
        do_reset();
        for (int i = 0; i < 10; i++) send_bit(w[i], 1'b1);
        checks++;
        if ({par_valid, comma_det, realign, locked} !== 4'b1101 || par_out !== 10'h17C) begin
            errors++;
            $display("[TB] FAIL initial_lock: flags=%b out=%h expected flags=1101 out=17c",
                     {par_valid, comma_det, realign, locked}, par_out);
        end
    endtask

    task automatic test_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        do_reset();
        checks++;
        if ({par_out, par_valid, comma_det, locked, realign} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: out=%h flags=%b expected all zero",
                     par_out, {par_valid, comma_det, locked, realign});
        end
    endtask

    task automatic test_lock_stream();
        logic [9:0] words [3];
        logic [3:0] exp;
        words[0] = 10'h17C;
        words[1] = 10'h2AA;
        words[2] = 10'h155;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 10; i++) begin
                send_bit(words[w][i], 1'b1);
                exp = {(i == 9), (i == 9 && w == 0), 1'b0, (w > 0 || i == 9)};
                checks++;
                if ({par_valid, comma_det, realign, locked} !== exp) begin
                    errors++;
                    $display("[TB] FAIL lock_stream_flags w%0d b%0d: got %b expected %b",
                             w, i, {par_valid, comma_det, realign, locked}, exp);
                end
                if (i == 9) begin
                    checks++;
                    if (par_out !== words[w]) begin
                        errors++;
                        $display("[TB] FAIL lock_stream_word w%0d: got %h expected %h",
                                 w, par_out, words[w]);
                    end
                end
                if (i == 4 && w > 0) begin
                    checks++;
                    if (par_out !== words[w-1]) begin
                        errors++;
                        $display("[TB] FAIL lock_stream_hold w%0d: got %h expected %h",
                                 w, par_out, words[w-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_arbitrary_phase();
        logic [22:0] s;
        logic [3:0]  exp;
        s = {10'h0F0, 10'h283, 3'b101};
        do_reset();
        for (int k = 0; k < 23; k++) begin
            send_bit(s[k], 1'b1);
            exp = {(k == 12 || k == 22), (k == 12), 1'b0, (k >= 12)};
            checks++;
            if ({par_valid, comma_det, realign, locked} !== exp) begin
                errors++;
                $display("[TB] FAIL phase_flags k%0d: got %b expected %b",
                         k, {par_valid, comma_det, realign, locked}, exp);
            end
        end
        checks++;
        if (par_out !== 10'h0F0) begin
            errors++;
            $display("[TB] FAIL phase_word: got %h expected 0f0", par_out);
        end
    endtask

    task automatic test_gapped();
        logic [9:0] words [3];
        logic [3:0] exp;
        logic       lk;
        words[0] = 10'h17C;
        words[1] = 10'h2AA;
        words[2] = 10'h155;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 10; i++) begin
                lk = (w > 0 || i == 9);
                send_bit(words[w][i], 1'b1);
                exp = {(i == 9), (i == 9 && w == 0), 1'b0, lk};
                checks++;
                if ({par_valid, comma_det, realign, locked} !== exp || (i == 9 && par_out !== words[w])) begin
                    errors++;
                    $display("[TB] FAIL gapped_valid w%0d b%0d: flags=%b out=%h expected flags=%b out=%h",
                             w, i, {par_valid, comma_det, realign, locked}, par_out, exp, words[w]);
                end
                send_bit(~words[w][i], 1'b0);
                checks++;
                if ({par_valid, comma_det, realign, locked} !== {3'b000, lk}) begin
                    errors++;
                    $display("[TB] FAIL gapped_idle w%0d b%0d: got %b expected %b",
                             w, i, {par_valid, comma_det, realign, locked}, {3'b000, lk});
                end
            end
        end
    endtask

    task automatic test_realign();
        logic [53:0] s;
        logic [3:0]  exp;
        logic [9:0]  exp_out;
        s = {10'h17C, 10'h17C, 10'h17C, 10'h17C, 10'h17C, 4'b0000};
        lock_on_17c();
        for (int j = 0; j < 54; j++) begin
            send_bit(s[j], 1'b1);
            exp_out = 10'h17C;
            case (j)
                9:       begin exp = 4'b1001; exp_out = 10'h3C0; end
                19, 29:  begin exp = 4'b1001; exp_out = 10'h3C5; end
                33:      exp = 4'b1111;
                43, 53:  exp = 4'b1101;
                default: exp = 4'b0001;
            endcase
            checks++;
            if ({par_valid, comma_det, realign, locked} !== exp) begin
                errors++;
                $display("[TB] FAIL realign_flags j%0d: got %b expected %b",
                         j, {par_valid, comma_det, realign, locked}, exp);
            end
            if (exp[3]) begin
                checks++;
                if (par_out !== exp_out) begin
                    errors++;
                    $display("[TB] FAIL realign_word j%0d: got %h expected %h", j, par_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_misalign_clear();
        logic [53:0] s;
        logic [3:0]  exp;
        logic [9:0]  exp_out;
        s = {10'h17C, 10'h17C, 4'b0000, 10'h17C, 6'b000000, 10'h17C, 4'b0000};
        lock_on_17c();
        for (int j = 0; j < 54; j++) begin
            send_bit(s[j], 1'b1);
            exp     = 4'b1001;
            exp_out = 10'h000;
            case (j)
                9, 39:   exp_out = 10'h3C0;
                19:      exp_out = 10'h005;
                29:      begin exp = 4'b1101; exp_out = 10'h17C; end
                49:      exp_out = 10'h3C5;
                default: exp = 4'b0001;
            endcase
            checks++;
            if ({par_valid, comma_det, realign, locked} !== exp) begin
                errors++;
                $display("[TB] FAIL misclear_flags j%0d: got %b expected %b",
                         j, {par_valid, comma_det, realign, locked}, exp);
            end
            if (exp[3]) begin
                checks++;
                if (par_out !== exp_out) begin
                    errors++;
                    $display("[TB] FAIL misclear_word j%0d: got %h expected %h", j, par_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [9:0] w2;
        logic [9:0] c;
        w2 = 10'h2AA;
        c  = 10'h17C;
        lock_on_17c();
        for (int i = 0; i < 5; i++) send_bit(w2[i], 1'b1);
        do_reset();
        checks++;
        if ({par_out, par_valid, comma_det, locked, realign} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL midword_reset: out=%h flags=%b expected all zero",
                     par_out, {par_valid, comma_det, locked, realign});
        end
        // These nine bits plus the cleared window bit spell the comma, but only nine are real
        for (int i = 1; i < 10; i++) begin
            send_bit(c[i], 1'b1);
            checks++;
            if ({par_valid, comma_det, realign, locked} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL midword_partial b%0d: got %b expected 0000",
                         i, {par_valid, comma_det, realign, locked});
            end
        end
        for (int i = 0; i < 10; i++) begin
            send_bit(c[i], 1'b1);
            checks++;
            if ({par_valid, comma_det, realign, locked} !== ((i == 9) ? 4'b1101 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL midword_relock b%0d: got %b expected %b",
                         i, {par_valid, comma_det, realign, locked}, (i == 9) ? 4'b1101 : 4'b0000);
            end
        end
        checks++;
        if (par_out !== 10'h17C) begin
            errors++;
            $display("[TB] FAIL midword_relock_word: got %h expected 17c", par_out);
        end
    endtask

    initial begin
        test_reset();
        test_lock_stream();
        test_arbitrary_phase();
        test_gapped();
        test_realign();
        test_misalign_clear();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
